decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, sets the immediate and PC width; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 4, sets the decoded-entry queue depth; it is a power of two in 2..16.
REQ-003 clk  in  1  Single clock; all state updates on the rising edge.
REQ-004 rst  in  1  Reset, asynchronous assert, active-high.
REQ-005 in_valid  in  1  Fetch offers an instruction this cycle.
REQ-006 in_ready  out  1  Stage accepts; equals !full, registered-state only, with no path from out_ready.
REQ-007 in_instr  in  32  Raw RV32I instruction word.
REQ-008 in_pc  in  XLEN  PC of in_instr.
REQ-009 flush  in  1  Discards all queued entries.
REQ-010 out_valid  out  1  The queue head is valid.
REQ-011 out_ready  in  1  The consumer takes the head.
REQ-012 out_ctrl  out  13  Control bundle of the head entry.
REQ-013 out_imm  out  XLEN  Sign-extended immediate of the head entry.
REQ-014 out_pc  out  XLEN  PC of the head entry.
REQ-015 out_rs1, out_rs2, out_rd  out  5 each  Register fields of the head entry, taken as raw bit slices [19:15], [24:20] and [11:7].
REQ-016 out_illegal  out  1  The head entry held an unsupported encoding.
REQ-017 illegal_cnt  out  16  Saturating count of illegal instructions accepted.

Function
REQ-018 The out_ctrl bit map SHALL be:
- [3:0] alu_op
- [4] alu_src_imm
- [5] reg_write
- [6] mem_to_reg
- [7] mem_write
- [8] mem_read
- [9] branch
- [10] jalr
- [11] jal
- [12] branch_ne
REQ-019 alu_op SHALL be derived from funct3 and apply to R-type and I-ALU only; load, store, branch, jal and jalr use alu_op 0.
- 000: add=0, or sub=8 when R-type and instr[30]=1.
- 001: sll=1.
- 010: slt=2.
- 011: sltu=3.
- 100: xor=4.
- 101: srl=5, or sra=13 when instr[30]=1.
- 110: or=6.
- 111: and=7.
REQ-020 Per opcode, out_ctrl bits outside [3:0] and out_imm SHALL be:
- 0110011 (R-type): bit 5; imm 0.
- 0010011 (I-ALU): bits 5,4; I-immediate.
- 0000011 (load): bits 8,6,5,4; I-immediate.
- 0100011 (store): bits 7,4; S-immediate.
- 1100011 (branch): bit 9, plus bit 12 when funct3=001; B-immediate.
- 1101111 (jal): bits 11,5; J-immediate.
- 1100111 (jalr): bits 10,5,4; I-immediate.
REQ-021 A branch with funct3 other than 000 or 001, and any other opcode, SHALL set out_illegal=1 with out_ctrl=0 and out_imm=0.
REQ-022 All immediates SHALL be sign-extended from instr[31] to XLEN; B- and J-immediates have bit 0 = 0.
REQ-023 Decode SHALL be combinational on the input side; the decoded entry is written into the queue on the handshake in_valid && in_ready.
REQ-024 Latency: an entry accepted in cycle N SHALL be presented on out_valid no earlier than N+1, and at N+1 when the queue was empty.
REQ-025 A pop SHALL occur on out_valid && out_ready; entries leave in FIFO order.
REQ-026 A simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-027 The write and read pointers SHALL wrap modulo DEPTH.
REQ-028 When full, in_ready SHALL be 0 even if out_ready=1 in that cycle; an offered instruction is not lost and must be held by the source.
REQ-029 When empty, out_valid SHALL be 0 and the head outputs SHALL hold their last values.
REQ-030 Flush SHALL, at the next edge, empty the queue (out_valid=0, occupancy 0).
REQ-031 A push or pop in the same cycle as flush SHALL be ignored, and illegal_cnt SHALL NOT count an instruction offered in a flush cycle.
REQ-032 illegal_cnt SHALL increment on each accepted illegal entry and saturate at 0xFFFF.

Reset
REQ-033 rst=1 SHALL immediately clear:
- pointers and occupancy
- out_valid=0, out_ctrl=0, out_imm=0, out_pc=0, out_illegal=0
- illegal_cnt=0
REQ-034 While rst=1, in_ready SHALL be 0; it SHALL become 1 in the first cycle after deassertion.
REQ-035 Reset asserted mid-operation SHALL discard all queued entries.

Verification
REQ-036 XLEN=32, push 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, out_ctrl=0x0020, out_rd=3, out_rs1=1, out_rs2=2, out_imm=0.
REQ-037 Push 0xFFC12283 (lw x5,-4(x2)) -> out_ctrl=0x0170, out_imm=0xFFFFFFFC; with XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFC.
REQ-038 Push 0xFE000CE3 (beq x0,x0,-8) -> out_ctrl=0x0200, out_imm=0xFFFFFFF8; push 0x00000000 -> out_illegal=1, out_ctrl=0, illegal_cnt=1.
REQ-039 DEPTH=4, out_ready=0, in_valid=1 for 6 cycles with distinct PCs -> exactly 4 accepted, in_ready=0 from the 5th cycle; then raise out_ready -> PCs emerge in order, in_ready returns 1 the cycle after the first pop.
REQ-040 Queue holding 3 entries, assert flush together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, occupancy 0, illegal_cnt unchanged.
REQ-041 Assert rst mid-stream with 2 entries queued -> out_valid=0 in the same cycle, without waiting for an edge; the first push after release appears at N+1.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming instruction word
// feeding a DEPTH-entry FIFO of decoded entries, with a registered head.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [12:0]     out_ctrl,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic [15:0]     illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic            illegal;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [12:0]     ctrl;
  } entry_t;

  // ALU operation from funct3; sub only exists for R-type, sra for both.
  function automatic logic [3:0] alu_op_f(input logic [2:0] f3,
                                          input logic       bit30,
                                          input logic       is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && bit30) ? 4'd8 : 4'd0;
      3'b101:  op = bit30 ? 4'd13 : 4'd5;
      default: op = {1'b0, f3};
    endcase
    return op;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j  = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};

  entry_t dec;

  // Decode the offered instruction into a queue entry.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
    dec         = '0;
    dec.pc      = in_pc;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    case (opcode)
      OP_R: begin
        dec.ctrl[3:0] = alu_op_f(funct3, in_instr[30], 1'b1);
        dec.ctrl[5]   = 1'b1;
      end
      OP_I: begin
        dec.ctrl[3:0] = alu_op_f(funct3, in_instr[30], 1'b0);
        dec.ctrl[5]   = 1'b1;
        dec.ctrl[4]   = 1'b1;
        dec.imm       = imm_i;
      end
      OP_LOAD: begin
        dec.ctrl[8] = 1'b1;
        dec.ctrl[6] = 1'b1;
        dec.ctrl[5] = 1'b1;
        dec.ctrl[4] = 1'b1;
        dec.imm     = imm_i;
      end
      OP_ST: begin
        dec.ctrl[7] = 1'b1;
        dec.ctrl[4] = 1'b1;
        dec.imm     = imm_s;
      end
      OP_BR: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec.ctrl[9]  = 1'b1;
          dec.ctrl[12] = (funct3 == 3'b001);
          dec.imm      = imm_b;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_JAL: begin
        dec.ctrl[11] = 1'b1;
        dec.ctrl[5]  = 1'b1;
        dec.imm      = imm_j;
      end
      OP_JALR: begin
        dec.ctrl[10] = 1'b1;
        dec.ctrl[5]  = 1'b1;
        dec.ctrl[4]  = 1'b1;
        dec.imm      = imm_i;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CW-1:0]  count_q, count_d;
  entry_t         head_q, head_d;
  logic           valid_q, valid_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           full, push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = valid_q && out_ready && !flush;
  assign rd_nxt   = rd_ptr_q + AW'(1);

  // Next-state for pointers, occupancy, registered head and illegal counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_nxt;
      count_d = count_q + CW'(push) - CW'(pop);
      // The head register tracks whichever entry is at the front after this edge.
      if (count_d != '0) begin
        if (count_q == '0 || (pop && count_q == CW'(1))) head_d = dec;
        else if (pop)                                    head_d = mem_q[rd_nxt];
      end
      if (push && dec.illegal && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
    valid_d = (count_d != '0);
  end

  // Queue storage; written only on an accepted push.
  // NOTE: storage is not reset; occupancy and pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  // Control state and registered head, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_ctrl    = head_q.ctrl;
  assign out_imm     = head_q.imm;
  assign out_pc      = head_q.pc;
  assign out_rs1     = head_q.rs1;
  assign out_rs2     = head_q.rs2;
  assign out_rd      = head_q.rd;
  assign out_illegal = head_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule
